// File: rtl/mini_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_alu_pkg
// Description : Shared constants for the mini_alu sequencer: state encoding
//               of the LOAD -> MUL -> OUT cycle and the shift-add step count.
// Revision    : 1.0 - initial release
// ============================================================================
package mini_alu_pkg;

    // Sequencer state encoding
    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_S_LOAD = 2'd0;
    localparam logic [c_STATE_W-1:0] c_S_MUL  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_S_OUT  = 2'd2;

    // Number of shift-add iterations for the 4x4 product
    localparam int unsigned MUL_STEPS = 4;

    // Counter width and the value of the final MUL step
    localparam int unsigned c_CNT_W = 2;
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(MUL_STEPS - 1);

endpackage : mini_alu_pkg
`default_nettype wire

// File: rtl/mini_alu_mult2x2.sv
`default_nettype none
// ============================================================================
// Module      : mult2x2
// Description : Combinational 2x2 unsigned multiplier, 4-bit product (0..9).
// Revision    : 1.0 - initial release
// ============================================================================
module mult2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic [3:0] w_pp0;
    logic [3:0] w_pp1;

    // Partial products: b[0] selects a, b[1] selects a shifted by one
    always_comb begin
        w_pp0 = b[0] ? {2'b00, a}       : 4'd0;
        w_pp1 = b[1] ? {1'b0, a, 1'b0}  : 4'd0;
        p     = w_pp0 + w_pp1;
    end

endmodule : mult2x2
`default_nettype wire

// File: rtl/mini_alu.sv
`default_nettype none
// ============================================================================
// Module      : mini_alu
// Description : Free-running sequencer computing iA2*iB2 + iA*iB. Operands are
//               captured at LOAD, the 4x4 product is built by four shift-add
//               steps, and the sum with the 2x2 product is registered at OUT.
//               One result every 6 clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_alu
    import mini_alu_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] iA,
    input  logic [1:0] iB,
    input  logic [3:0] iA2,
    input  logic [3:0] iB2,
    output logic [7:0] oLed
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_stateNext;
    logic [c_CNT_W-1:0]   r_count;
    logic [1:0]           r_opA;
    logic [1:0]           r_opB;
    logic [3:0]           r_mcand;
    logic [3:0]           r_mplier;
    logic [7:0]           r_accum;
    logic [7:0]           r_led;
    logic [3:0]           w_smallProd;
    logic [7:0]           w_shiftedMcand;

    // 2x2 product of the captured operands
    mult2x2 u_mult2x2 (
        .a (r_opA),
        .b (r_opB),
        .p (w_smallProd)
    );

    // Multiplicand aligned to the current multiplier bit
    assign w_shiftedMcand = {4'd0, r_mcand} << r_count;

    // Sequencer state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= c_S_LOAD;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state: LOAD for one cycle, MUL until the last step, OUT for one cycle
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_S_LOAD: w_stateNext = c_S_MUL;
            c_S_MUL:  w_stateNext = (r_count == c_LAST_STEP) ? c_S_OUT : c_S_MUL;
            c_S_OUT:  w_stateNext = c_S_LOAD;
            default:  w_stateNext = c_S_LOAD;
        endcase
    end

    // Operand capture, shift-add accumulation and result register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count  <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_accum  <= '0;
            r_led    <= '0;
        end else begin
            case (r_state)
                c_S_LOAD: begin
                    r_opA    <= iA;
                    r_opB    <= iB;
                    r_mcand  <= iA2;
                    r_mplier <= iB2;
                    r_accum  <= '0;
                    r_count  <= '0;
                end
                c_S_MUL: begin
                    if (r_mplier[r_count]) begin
                        r_accum <= r_accum + w_shiftedMcand;
                    end
                    r_count <= r_count + 1'b1;
                end
                c_S_OUT: begin
                    // Max 225 + 9 = 234, so the 8-bit sum never wraps
                    r_led <= r_accum + {4'd0, w_smallProd};
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign oLed = r_led;

endmodule : mini_alu
`default_nettype wire

// File: tb/tb_mini_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mini_alu
// Description : Directed self-checking bench for mini_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_alu;

    logic       r_clk;
    logic       r_rst;
    logic [1:0] r_a;
    logic [1:0] r_b;
    logic [3:0] r_a2;
    logic [3:0] r_b2;
    logic [7:0] w_led;

    int r_vectors;
    int r_miscompares;

    mini_alu u_dut (
        .Clock (r_clk),
        .Reset (r_rst),
        .iA    (r_a),
        .iB    (r_b),
        .iA2   (r_a2),
        .iB2   (r_b2),
        .oLed  (w_led)
    );

    // 10 ns clock
    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [7:0] exp);
        r_vectors++;
        assert (w_led === exp)
        else begin
            r_miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, w_led, exp);
        end
    endtask

    task automatic setOps(input logic [1:0] a, input logic [1:0] b,
                          input logic [3:0] a2, input logic [3:0] b2);
        r_a  = a;
        r_b  = b;
        r_a2 = a2;
        r_b2 = b2;
    endtask

    task automatic waitEdges(input int n);
        for (int i = 0; i < n; i++) @(posedge r_clk);
        #1;
    endtask

    // Called just before a LOAD edge: checks oLed holds across the first five
    // edges and takes the new value at the sixth (OUT) edge.
    task automatic runVec(input string tag, input logic [1:0] a, input logic [1:0] b,
                          input logic [3:0] a2, input logic [3:0] b2,
                          input logic [7:0] prev, input logic [7:0] exp);
        setOps(a, b, a2, b2);
        waitEdges(5);
        check({tag, "_hold"}, prev);
        waitEdges(1);
        check(tag, exp);
    endtask

    initial begin
        r_vectors     = 0;
        r_miscompares = 0;
        r_rst         = 1'b0;
        setOps(2'd0, 2'd0, 4'd0, 4'd0);

        // Reset pulse, released away from a clock edge
        #2 r_rst = 1'b1;
        #1;
        check("reset", 8'h00);
        @(negedge r_clk);
        @(negedge r_clk);
        r_rst = 1'b0;

        runVec("v3x1_8x8",   2'd3, 2'd1, 4'd8,  4'd8,  8'h00, 8'h43);
        runVec("v1x2_15x15", 2'd1, 2'd2, 4'd15, 4'd15, 8'h43, 8'hE3);
        runVec("v2x2_0x0",   2'd2, 2'd2, 4'd0,  4'd0,  8'hE3, 8'h04);
        runVec("v3x3_7x5",   2'd3, 2'd3, 4'd7,  4'd5,  8'h04, 8'h2C);
        runVec("v0x0_11x13", 2'd0, 2'd0, 4'd11, 4'd13, 8'h2C, 8'h8F);
        runVec("vmax",       2'd3, 2'd3, 4'd15, 4'd15, 8'h8F, 8'd234);
        runVec("v2x3_12x10", 2'd2, 2'd3, 4'd12, 4'd10, 8'd234, 8'd126);
        runVec("vzero",      2'd0, 2'd3, 4'd15, 4'd0,  8'd126, 8'd0);

        // Late input change after the LOAD edge must be ignored: 7*7 + 1*2
        setOps(2'd1, 2'd2, 4'd7, 4'd7);
        waitEdges(1);
        setOps(2'd3, 2'd3, 4'd5, 4'd5);
        waitEdges(5);
        check("late_change", 8'd51);

        // Reset mid-MUL: 9*9 + 3*3 = 90 would be the result without reset
        setOps(2'd3, 2'd3, 4'd9, 4'd9);
        waitEdges(3);
        r_rst = 1'b1;
        #1;
        check("reset_midmul", 8'h00);
        @(negedge r_clk);
        @(negedge r_clk);
        check("reset_hold", 8'h00);
        r_rst = 1'b0;
        // First edge after release is LOAD
        runVec("after_reset", 2'd2, 2'd1, 4'd6, 4'd9, 8'h00, 8'd56);
        runVec("v1x1_1x1",    2'd1, 2'd1, 4'd1, 4'd1, 8'd56, 8'd2);

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mini_alu
`default_nettype wire
